// File: rtl/hd_controller_if.sv
// hd_controller_if: CPU request/response and disk-side signals of the hard-disk controller
interface hd_controller_if #(parameter int DATA_WIDTH = 32);
  logic                  req;
  logic                  we;
  logic [DATA_WIDTH-1:0] reqTrack;
  logic [DATA_WIDTH-1:0] reqPos;
  logic [DATA_WIDTH-1:0] reqWriteData;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdData;
  logic [DATA_WIDTH-1:0] hdTrack;
  logic [DATA_WIDTH-1:0] hdTrackPos;
  logic [DATA_WIDTH-1:0] hdWriteData;
  logic                  hdFlag;
  logic [DATA_WIDTH-1:0] hdReadData;
  modport master (
    output req, we, reqTrack, reqPos, reqWriteData, hdReadData,
    input  busy, done, err, rdData, hdTrack, hdTrackPos, hdWriteData, hdFlag
  );
  modport slave (
    input  req, we, reqTrack, reqPos, reqWriteData, hdReadData,
    output busy, done, err, rdData, hdTrack, hdTrackPos, hdWriteData, hdFlag
  );
endinterface

// File: rtl/hd_controller.sv
// hd_controller: single-request disk sequencer with optional head seek timing.
// Define HD_SEEK_DELAY_EN to add the SEEK state and its per-track delay counter.
module hd_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 1024,
  parameter int TRACKS      = 4,
  parameter int SEEK_CYCLES = 8
) (
  input logic clock,
  input logic reset,
  hd_controller_if.slave bus
);
  localparam int WPT = ADDR_WIDTH / TRACKS;
  typedef enum logic [2:0] {IDLE, SEEK, ACCESS, RDWAIT, DONE} state_t;
  state_t                state;
  logic                  we_q;
  logic                  bad;
  logic [DATA_WIDTH-1:0] head;
  always_comb bad = bus.reqTrack >= DATA_WIDTH'(TRACKS) || bus.reqPos >= DATA_WIDTH'(WPT);
`ifdef HD_SEEK_DELAY_EN
  localparam int CW = $clog2((TRACKS - 1) * SEEK_CYCLES + 2);
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] dist;
  always_comb dist = bus.reqTrack > head ? bus.reqTrack - head : head - bus.reqTrack;
`else
  logic unused_head;
  assign unused_head = ^head;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      we_q            <= 1'b0;
      head            <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.hdFlag      <= 1'b0;
      bus.rdData      <= '0;
      bus.hdTrack     <= '0;
      bus.hdTrackPos  <= '0;
      bus.hdWriteData <= '0;
`ifdef HD_SEEK_DELAY_EN
      cnt             <= '0;
`endif
    end else begin
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.hdFlag <= 1'b0;
      case (state)
        IDLE: if (bus.req) begin
          we_q            <= bus.we;
          bus.hdTrack     <= bus.reqTrack;
          bus.hdTrackPos  <= bus.reqPos;
          bus.hdWriteData <= bus.reqWriteData;
          bus.busy        <= 1'b1;
          if (bad) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.err  <= 1'b1;
          end
`ifdef HD_SEEK_DELAY_EN
          else if (dist != '0) begin
            cnt   <= CW'(dist * SEEK_CYCLES);
            state <= SEEK;
          end
`endif
          else begin
            state      <= ACCESS;
            bus.hdFlag <= bus.we;
          end
        end
`ifdef HD_SEEK_DELAY_EN
        SEEK: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            head       <= bus.hdTrack;
            state      <= ACCESS;
            bus.hdFlag <= we_q;
          end
        end
`endif
        ACCESS: begin
          head     <= bus.hdTrack;
          state    <= we_q ? DONE : RDWAIT;
          bus.done <= we_q;
        end
        RDWAIT: begin
          bus.rdData <= bus.hdReadData;
          state      <= DONE;
          bus.done   <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
